hr_session_monitor: RTL and testbench

Parametrised workout-session monitor; next generation of the step/heart-rate calculator. Runs a start/pause/stop session state machine on one clock and accepts heart-rate and step samples only while running. Keeps a DEPTH-sample moving average of heart rate, session min/max, saturating step and sample counters, a registered zone classification, and a debounced emergency alarm. Sits between the sensor sampling logic and the display/feedback logic.

---
 rtl/hr_session_pkg.sv | 31 +++
 rtl/hr_window_avg.sv | 76 +++++++
 rtl/hr_session_monitor.sv | 171 +++++++++++++++++
 tb/tb_hr_session_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hr_session_pkg.sv
// Shared encodings for the heart-rate session monitor: session states, zone codes
// and the index-width helper used to size localparams.
package hr_session_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ZONE_SAFE  = 2'd0,
        ZONE_WARN  = 2'd1,
        ZONE_EMERG = 2'd2
    } zone_e;

    // Control pulses after stop > pause > start priority has been applied.
    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_START = 2'd1,
        CMD_PAUSE = 2'd2,
        CMD_STOP  = 2'd3
    } cmd_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hr_window_avg.sv
// DEPTH-entry circular window of heart-rate samples with a running sum, registered
// average (missing entries count as zero) and a fill flag.
module hr_window_avg
    import hr_session_pkg::*;
#(
    parameter int unsigned HR_W  = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            push,
    input  logic [HR_W-1:0] din,
    output logic [HR_W-1:0] avg,
    output logic            full
);

    localparam int unsigned AW    = idx_w(DEPTH);
    localparam int unsigned SUM_W = HR_W + AW;
    localparam logic [AW:0] FILL_MAX = DEPTH[AW:0];

    logic [HR_W-1:0]  win_q [DEPTH];
    logic [HR_W-1:0]  win_d [DEPTH];
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic [HR_W-1:0]  avg_q, avg_d;

    always_comb begin
        win_d  = win_q;
        sum_d  = sum_q;
        ptr_d  = ptr_q;
        fill_d = fill_q;
        avg_d  = avg_q;
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_d[i] = '0;
            end
            sum_d  = '0;
            ptr_d  = '0;
            fill_d = '0;
            avg_d  = '0;
        end else if (push) begin
            // The evicted slot is already part of the sum, so the difference never underflows.
            win_d[ptr_q] = din;
            sum_d        = sum_q + SUM_W'(din) - SUM_W'(win_q[ptr_q]);
            ptr_d        = ptr_q + 1'b1;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
            avg_d = HR_W'(sum_d >> AW);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q  <= '0;
            ptr_q  <= '0;
            fill_q <= '0;
            avg_q  <= '0;
        end else begin
            win_q  <= win_d;
            sum_q  <= sum_d;
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
            avg_q  <= avg_d;
        end
    end

    assign avg  = avg_q;
    assign full = (fill_q == FILL_MAX);

endmodule

// File: rtl/hr_session_monitor.sv
// Workout-session monitor: start/pause/stop session FSM gating heart-rate and step
// samples into moving average, min/max, saturating counters, zone and alarm.
module hr_session_monitor
    import hr_session_pkg::*;
#(
    parameter int unsigned HR_W       = 8,
    parameter int unsigned STEP_W     = 16,
    parameter int unsigned TIME_W     = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned WARN_TH    = 150,
    parameter int unsigned EMERG_TH   = 180,
    parameter int unsigned ALARM_HOLD = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [HR_W-1:0]   hr_in,
    input  logic [1:0]        steps_in,
    output logic [1:0]        state,
    output logic [HR_W-1:0]   avg_hr,
    output logic              avg_valid,
    output logic [HR_W-1:0]   max_hr,
    output logic [HR_W-1:0]   min_hr,
    output logic [STEP_W-1:0] total_steps,
    output logic [TIME_W-1:0] elapsed,
    output logic [1:0]        hr_zone,
    output logic              alarm
);

    localparam int unsigned     AC_W      = idx_w(ALARM_HOLD + 1);
    localparam logic [AC_W-1:0] AC_MAX    = ALARM_HOLD[AC_W-1:0];
    localparam logic [HR_W-1:0] WARN_LIM  = WARN_TH[HR_W-1:0];
    localparam logic [HR_W-1:0] EMERG_LIM = EMERG_TH[HR_W-1:0];

    state_e            state_q, state_d;
    cmd_e              cmd;
    logic              clr;
    logic              accept;
    zone_e             zone_in;
    zone_e             zone_q, zone_d;
    logic [HR_W-1:0]   max_q, max_d;
    logic [HR_W-1:0]   min_q, min_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [TIME_W-1:0] elapsed_q, elapsed_d;
    logic [AC_W-1:0]   acnt_q, acnt_d;
    logic [STEP_W:0]   steps_sum;
    logic [TIME_W:0]   elapsed_sum;

    // Only the highest-priority pulse acts; if it means nothing in this state we hold.
    always_comb begin
        cmd     = stop  ? CMD_STOP  :
                  pause ? CMD_PAUSE :
                  start ? CMD_START : CMD_NONE;
        state_d = state_q;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cmd == CMD_START) begin
                    state_d = ST_RUN;
                    clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (cmd == CMD_STOP) begin
                    state_d = ST_DONE;
                end else if (cmd == CMD_PAUSE) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (cmd == CMD_STOP) begin
                    state_d = ST_DONE;
                end else if (cmd == CMD_START) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = sample_valid && (state_q == ST_RUN);

    always_comb begin
        zone_in = (hr_in <= WARN_LIM)  ? ZONE_SAFE :
                  (hr_in <= EMERG_LIM) ? ZONE_WARN : ZONE_EMERG;
    end

    always_comb begin
        max_d       = max_q;
        min_d       = min_q;
        steps_d     = steps_q;
        elapsed_d   = elapsed_q;
        zone_d      = zone_q;
        acnt_d      = acnt_q;
        steps_sum   = {1'b0, steps_q} + (STEP_W + 1)'(steps_in);
        elapsed_sum = {1'b0, elapsed_q} + 1'b1;
        if (clr) begin
            max_d     = '0;
            min_d     = '1;
            steps_d   = '0;
            elapsed_d = '0;
            zone_d    = ZONE_SAFE;
            acnt_d    = '0;
        end else if (accept) begin
            if (hr_in > max_q) begin
                max_d = hr_in;
            end
            if (hr_in < min_q) begin
                min_d = hr_in;
            end
            steps_d   = steps_sum[STEP_W]   ? '1 : steps_sum[STEP_W-1:0];
            elapsed_d = elapsed_sum[TIME_W] ? '1 : elapsed_sum[TIME_W-1:0];
            zone_d    = zone_in;
            // Warning-zone samples neither build nor break an emergency run.
            unique case (zone_in)
                ZONE_EMERG: begin
                    if (acnt_q != AC_MAX) begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
                ZONE_SAFE: acnt_d = '0;
                default:   acnt_d = acnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            max_q     <= '0;
            min_q     <= '1;
            steps_q   <= '0;
            elapsed_q <= '0;
            zone_q    <= ZONE_SAFE;
            acnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            min_q     <= min_d;
            steps_q   <= steps_d;
            elapsed_q <= elapsed_d;
            zone_q    <= zone_d;
            acnt_q    <= acnt_d;
        end
    end

    hr_window_avg #(
        .HR_W  (HR_W),
        .DEPTH (DEPTH)
    ) u_window (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .push (accept),
        .din  (hr_in),
        .avg  (avg_hr),
        .full (avg_valid)
    );

    assign state       = state_q;
    assign max_hr      = max_q;
    assign min_hr      = min_q;
    assign total_steps = steps_q;
    assign elapsed     = elapsed_q;
    assign hr_zone     = zone_q;
    assign alarm       = (acnt_q == AC_MAX);

endmodule

// File: tb/tb_hr_session_monitor.sv
// Scoreboard bench for hr_session_monitor: a session-level reference model queues
// expected outputs per clock; a negedge monitor pops and compares them.
module tb_hr_session_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, pause, stop, sample_valid;
    logic [7:0]  hr_in;
    logic [1:0]  steps_in;

    logic [1:0]  state,  s_state;
    logic [7:0]  avg_hr, s_avg_hr, max_hr, s_max_hr, min_hr, s_min_hr;
    logic        avg_valid, s_avg_valid, alarm, s_alarm;
    logic [15:0] total_steps, elapsed;
    logic [3:0]  s_total_steps, s_elapsed;
    logic [1:0]  hr_zone, s_hr_zone;

    always #5 clk = ~clk;

    hr_session_monitor dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
        .sample_valid(sample_valid), .hr_in(hr_in), .steps_in(steps_in),
        .state(state), .avg_hr(avg_hr), .avg_valid(avg_valid), .max_hr(max_hr),
        .min_hr(min_hr), .total_steps(total_steps), .elapsed(elapsed),
        .hr_zone(hr_zone), .alarm(alarm)
    );

    // Narrow counters so step and sample saturation are reachable quickly.
    hr_session_monitor #(.STEP_W(4), .TIME_W(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
        .sample_valid(sample_valid), .hr_in(hr_in), .steps_in(steps_in),
        .state(s_state), .avg_hr(s_avg_hr), .avg_valid(s_avg_valid), .max_hr(s_max_hr),
        .min_hr(s_min_hr), .total_steps(s_total_steps), .elapsed(s_elapsed),
        .hr_zone(s_hr_zone), .alarm(s_alarm)
    );

    typedef struct {
        int st, avg, av, mx, mn, stp, el, zn, al, st_s, stp_s, el_s;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: session state, accepted-sample history and statistics.
    int m_state;
    int m_hist[$];
    int m_max, m_min, m_steps, m_el, m_steps_s, m_el_s, m_zone, m_acnt;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_clear_stats();
        m_hist.delete();
        m_max = 0; m_min = 255; m_steps = 0; m_el = 0;
        m_steps_s = 0; m_el_s = 0; m_zone = 0; m_acnt = 0;
    endtask

    task automatic model_reset();
        m_state = 0;
        model_clear_stats();
    endtask

    task automatic model_step(input bit s, input bit p, input bit t,
                              input bit v, input int h, input int k);
        bit acc;
        int z;
        acc = v && (m_state == 1);
        if (acc) begin
            m_hist.push_back(h);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            if (h > m_max) m_max = h;
            if (h < m_min) m_min = h;
            m_steps   = imin(m_steps + k, 65535);
            m_steps_s = imin(m_steps_s + k, 15);
            m_el      = imin(m_el + 1, 65535);
            m_el_s    = imin(m_el_s + 1, 15);
            z = (h <= 150) ? 0 : (h <= 180) ? 1 : 2;
            m_zone = z;
            if (z == 2) m_acnt = imin(m_acnt + 1, 3);
            else if (z == 0) m_acnt = 0;
        end
        if (t) begin
            if (m_state == 1 || m_state == 2) m_state = 3;
        end else if (p) begin
            if (m_state == 1) m_state = 2;
        end else if (s) begin
            if (m_state == 0 || m_state == 3) begin
                m_state = 1;
                model_clear_stats();
            end else if (m_state == 2) begin
                m_state = 1;
            end
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        int sum;
        sum = 0;
        foreach (m_hist[i]) sum += m_hist[i];
        e.st = m_state;    e.avg = sum / 8;   e.av = (m_hist.size() == 8) ? 1 : 0;
        e.mx = m_max;      e.mn = m_min;      e.stp = m_steps;
        e.el = m_el;       e.zn = m_zone;     e.al = (m_acnt == 3) ? 1 : 0;
        e.st_s = m_state;  e.stp_s = m_steps_s; e.el_s = m_el_s;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("state",       int'(state),         e.st);
                chk("avg_hr",      int'(avg_hr),        e.avg);
                chk("avg_valid",   int'(avg_valid),     e.av);
                chk("max_hr",      int'(max_hr),        e.mx);
                chk("min_hr",      int'(min_hr),        e.mn);
                chk("total_steps", int'(total_steps),   e.stp);
                chk("elapsed",     int'(elapsed),       e.el);
                chk("hr_zone",     int'(hr_zone),       e.zn);
                chk("alarm",       int'(alarm),         e.al);
                chk("s_state",     int'(s_state),       e.st_s);
                chk("s_steps",     int'(s_total_steps), e.stp_s);
                chk("s_elapsed",   int'(s_elapsed),     e.el_s);
            end
        end
    end

    task automatic cycle(input bit s, input bit p, input bit t,
                         input bit v, input int h, input int k);
        start = s; pause = p; stop = t; sample_valid = v;
        hr_in = 8'(h); steps_in = 2'(k);
        @(posedge clk);
        model_step(s, p, t, v, h, k);
        #1 sbq.push_back(snap());
    endtask

    // Idle edge, then a short reset pulse strictly between edges.
    task automatic async_rst();
        start = 0; pause = 0; stop = 0; sample_valid = 0;
        @(posedge clk);
        model_step(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        sbq.push_back(snap());
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int r;
        rst = 1'b1; start = 0; pause = 0; stop = 0; sample_valid = 0;
        hr_in = '0; steps_in = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 sbq.push_back(snap());
        rst = 1'b0;

        // First session: steady 100 bpm, then window wrap to 140.
        cycle(1, 0, 0, 1, 90, 1);
        repeat (8) cycle(0, 0, 0, 1, 100, 2);
        repeat (8) cycle(0, 0, 0, 1, 140, 1);
        // Alarm build-up, hold through warning, clear on safe.
        cycle(0, 0, 0, 1, 185, 0);
        cycle(0, 0, 0, 1, 185, 0);
        cycle(0, 0, 0, 1, 170, 0);
        cycle(0, 0, 0, 1, 185, 0);
        cycle(0, 0, 0, 1, 170, 0);
        cycle(0, 0, 0, 1, 120, 0);
        // Pause with a sample, ignored samples, resume, then stop+pause together.
        cycle(0, 1, 0, 1, 130, 1);
        repeat (3) cycle(0, 0, 0, 1, 200, 3);
        cycle(1, 0, 0, 1, 60, 1);
        repeat (3) cycle(0, 0, 0, 1, 155, 1);
        cycle(0, 1, 1, 1, 99, 2);
        repeat (2) cycle(0, 0, 0, 1, 50, 3);
        // Restart from DONE clears stats; start-cycle sample is ignored.
        cycle(1, 0, 0, 1, 77, 3);
        repeat (20) cycle(0, 0, 0, 1, 110, 3);
        cycle(0, 0, 0, 1, 190, 2);
        async_rst();
        cycle(0, 0, 0, 1, 100, 1);

        // Randomized sessions with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                async_rst();
            end else begin
                cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
                      ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                      $urandom_range(60, 220), $urandom_range(0, 3));
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
